// File: rtl/hnf_rxreq_lcrd_ctrl.sv
// CHI HNF RXREQ link-layer controller: receiver link activation handshake, L-credit
// issue gated by posq space, credit/occupancy tracking and sticky protocol-error flag.
module hnf_rxreq_lcrd_ctrl #(
   parameter  int unsigned NUM_CREDITS = 4,
   localparam int unsigned CW          = $clog2(NUM_CREDITS + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          RXLINKACTIVEREQ,
   output logic          RXLINKACTIVEACK,
   input  logic          RXREQFLITV,
   input  logic          rxreq_flit_is_lcrdret,
   output logic          RXREQLCRDV,
   output logic          rxreq_recv_en,
   input  logic          rxreq_posq_pop,
   output logic [CW-1:0] lcrd_outstanding,
   output logic [CW-1:0] posq_occupancy,
   output logic          proto_err
);

   typedef enum logic [1:0] {StStop, StRun, StDeact} state_e;

   localparam logic [CW:0] MaxCnt = (CW+1)'(NUM_CREDITS);

   state_e        r_state, w_state_d;
   logic [CW-1:0] r_out, r_occ, w_out_d, w_occ_d;
   logic          r_lcrdv, w_lcrdv_d;
   logic          r_ack, r_err;
   logic          w_cons, w_recv, w_err_evt;
   logic [CW:0]   w_out_inc, w_occ_inc, w_out_net, w_occ_net, w_total;

   // Counter next-state; saturation at 0/NUM_CREDITS only matters on protocol errors.
   always_comb begin
      w_cons    = RXREQFLITV & (r_state != StStop);
      w_recv    = w_cons & ~rxreq_flit_is_lcrdret;
      w_err_evt = (RXREQFLITV & (r_state == StStop))
                | (RXREQFLITV & (r_out == '0) & ~r_lcrdv)
                | (rxreq_posq_pop & (r_occ == '0));
      w_out_inc = {1'b0, r_out} + {{CW{1'b0}}, r_lcrdv};
      w_occ_inc = {1'b0, r_occ} + {{CW{1'b0}}, w_recv};
      w_out_net = (w_cons && (w_out_inc == '0)) ? '0 : w_out_inc - {{CW{1'b0}}, w_cons};
      w_occ_net = (rxreq_posq_pop && (w_occ_inc == '0)) ? '0
                : w_occ_inc - {{CW{1'b0}}, rxreq_posq_pop};
      w_out_d   = (w_out_net > MaxCnt) ? MaxCnt[CW-1:0] : w_out_net[CW-1:0];
      w_occ_d   = (w_occ_net > MaxCnt) ? MaxCnt[CW-1:0] : w_occ_net[CW-1:0];
      w_total   = {1'b0, w_out_d} + {1'b0, w_occ_d};
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StStop:  if (RXLINKACTIVEREQ)  w_state_d = StRun;
         StRun:   if (!RXLINKACTIVEREQ) w_state_d = StDeact;
         StDeact: if (w_out_d == '0)    w_state_d = StStop;
         default: w_state_d = StStop;
      endcase
      // Credits start only once ACK is already visible and stop on the edge leaving RUN.
      w_lcrdv_d = (r_state == StRun) && (w_state_d == StRun) && (w_total < MaxCnt);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= StStop;
         r_out   <= '0;
         r_occ   <= '0;
         r_lcrdv <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_out   <= w_out_d;
         r_occ   <= w_occ_d;
         r_lcrdv <= w_lcrdv_d;
         r_ack   <= (w_state_d != StStop);
         r_err   <= r_err | w_err_evt;
      end
   end

   assign RXLINKACTIVEACK  = r_ack;
   assign RXREQLCRDV       = r_lcrdv;
   assign rxreq_recv_en    = w_recv;
   assign lcrd_outstanding = r_out;
   assign posq_occupancy   = r_occ;
   assign proto_err        = r_err;

endmodule

// File: tb/tb_hnf_rxreq_lcrd_ctrl.sv
// Bench for hnf_rxreq_lcrd_ctrl: directed link/credit scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the credit and link rules.
module tb_hnf_rxreq_lcrd_ctrl;

   localparam int N  = 4;
   localparam int CW = $clog2(N + 1);
   localparam int M_STOP  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DEACT = 2;

   logic          clock = 1'b0;
   logic          reset, req, ack, flitv, lcr, lcrdv, recv_en, pop, err;
   logic [CW-1:0] out, occ;

   int checks = 0;
   int errors = 0;

   int m_mode, m_out, m_occ;
   bit m_lcrdv, m_err;

   int pulses, first;
   bit r_req, fv, lr, pp, rs, legal;

   always #5 clock = ~clock;

   hnf_rxreq_lcrd_ctrl #(.NUM_CREDITS(N)) dut (
      .clock                 (clock),
      .reset                 (reset),
      .RXLINKACTIVEREQ       (req),
      .RXLINKACTIVEACK       (ack),
      .RXREQFLITV            (flitv),
      .rxreq_flit_is_lcrdret (lcr),
      .RXREQLCRDV            (lcrdv),
      .rxreq_recv_en         (recv_en),
      .rxreq_posq_pop        (pop),
      .lcrd_outstanding      (out),
      .posq_occupancy        (occ),
      .proto_err             (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp)) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : ((v > N) ? N : v);
   endfunction

   // Reference: counts held as plain integers, link as a three-mode value.
   task automatic model_update(input bit rst, input bit rq, input bit f, input bit l,
                               input bit p);
      bit live;
      int cons, enq, n_out, n_occ, n_mode;
      if (rst) begin
         m_mode = M_STOP; m_out = 0; m_occ = 0; m_lcrdv = 0; m_err = 0;
      end else begin
         live  = (m_mode != M_STOP);
         cons  = (f && live) ? 1 : 0;
         enq   = (f && !l && live) ? 1 : 0;
         if (f && (!live || (m_out == 0 && !m_lcrdv))) m_err = 1;
         if (p && m_occ == 0) m_err = 1;
         n_out  = clamp(m_out + int'(m_lcrdv) - cons);
         n_occ  = clamp(m_occ + enq - int'(p));
         n_mode = m_mode;
         if (m_mode == M_STOP && rq) n_mode = M_RUN;
         else if (m_mode == M_RUN && !rq) n_mode = M_DEACT;
         else if (m_mode == M_DEACT && n_out == 0) n_mode = M_STOP;
         m_lcrdv = (m_mode == M_RUN) && (n_mode == M_RUN) && (n_out + n_occ < N);
         m_mode  = n_mode;
         m_out   = n_out;
         m_occ   = n_occ;
      end
   endtask

   task automatic tick(input bit rst, input bit rq, input bit f, input bit l, input bit p);
      reset = rst; req = rq; flitv = f; lcr = l; pop = p;
      #1;
      chk("recv_en", recv_en, (f && !l && m_mode != M_STOP) ? 1 : 0);
      @(posedge clock);
      model_update(rst, rq, f, l, p);
      #1;
      chk("m_ack", ack, (m_mode != M_STOP) ? 1 : 0);
      chk("m_lcrdv", lcrdv, int'(m_lcrdv));
      chk("m_out", out, m_out);
      chk("m_occ", occ, m_occ);
      chk("m_err", err, int'(m_err));
      if (!m_err) chk("invariant", (int'(out) + int'(occ) <= N) ? 1 : 0, 1);
   endtask

   task automatic activate();
      tick(0, 1, 0, 0, 0);
      chk("act_ack", ack, 1);
      chk("act_lcrdv_c1", lcrdv, 0);
      pulses = 0; first = -1;
      for (int c = 2; c <= 8; c++) begin
         tick(0, 1, 0, 0, 0);
         if (lcrdv === 1'b1) begin
            pulses++;
            if (first < 0) first = c;
         end
      end
      chk("credit_pulses", pulses, 4);
      chk("first_credit_cycle", first, 2);
      chk("out_after_act", out, 4);
   endtask

   initial begin
      reset = 1; req = 0; flitv = 0; lcr = 0; pop = 0;
      m_mode = M_STOP; m_out = 0; m_occ = 0; m_lcrdv = 0; m_err = 0;

      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      chk("rst_ack", ack, 0);
      chk("rst_lcrdv", lcrdv, 0);
      chk("rst_out", out, 0);
      chk("rst_err", err, 0);

      activate();

      for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 0);
      chk("full_occ", occ, 4);
      chk("full_out", out, 0);
      chk("full_lcrdv", lcrdv, 0);
      tick(0, 1, 0, 0, 0);
      chk("full_idle_lcrdv", lcrdv, 0);
      tick(0, 1, 0, 0, 1);
      chk("pop_credit_t1", lcrdv, 1);
      tick(0, 1, 0, 0, 0);
      chk("pop_credit_t2", lcrdv, 0);

      tick(0, 1, 0, 0, 1);
      tick(0, 1, 0, 0, 1);
      chk("pre_same_out", out, 2);
      chk("pre_same_occ", occ, 1);
      chk("pre_same_lcrdv", lcrdv, 1);
      tick(0, 1, 1, 0, 1);
      chk("same_out", out, 2);
      chk("same_occ", occ, 1);
      chk("same_err", err, 0);
      tick(0, 1, 0, 0, 0);
      chk("settle_out", out, 3);
      chk("settle_occ", occ, 1);

      tick(1, 1, 0, 0, 0);
      chk("midrst_ack", ack, 0);
      chk("midrst_lcrdv", lcrdv, 0);
      chk("midrst_out", out, 0);
      chk("midrst_occ", occ, 0);
      tick(0, 0, 0, 0, 0);
      chk("post_rst_lcrdv", lcrdv, 0);
      activate();

      tick(0, 0, 1, 0, 0);
      chk("deact_out", out, 3);
      chk("deact_ack", ack, 1);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 1, 1, 0);
         chk("deact_lcrdv", lcrdv, 0);
         chk("deact_ack_step", ack, (i == 2) ? 0 : 1);
      end
      chk("stop_keeps_occ", occ, 1);
      tick(0, 0, 0, 0, 1);
      chk("stop_pop_occ", occ, 0);
      chk("stop_pop_err", err, 0);

      activate();
      for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 0);
      tick(0, 1, 1, 0, 0);
      chk("nocred_err", err, 1);
      chk("nocred_out", out, 0);
      chk("nocred_occ_sat", occ, 4);
      for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
      chk("err_sticky", err, 1);
      tick(1, 0, 0, 0, 0);
      chk("err_cleared", err, 0);
      tick(0, 0, 0, 0, 1);
      chk("pop_empty_err", err, 1);
      chk("pop_empty_occ", occ, 0);
      tick(0, 0, 0, 0, 0);
      chk("pop_empty_sticky", err, 1);

      tick(1, 0, 0, 0, 0);
      r_req = 1;
      for (int i = 0; i < 3000; i++) begin
         rs = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 49) == 0) r_req = !r_req;
         legal = (m_mode != M_STOP) && (m_out > 0 || m_lcrdv);
         fv = legal ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 99) == 0);
         lr = ($urandom_range(0, 3) == 0);
         pp = (m_occ > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
         tick(rs, r_req, fv, lr, pp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
